// File: rtl/fir4_avg_outbuf.sv
// fir4_avg_outbuf
//   Output stage for the 4-tap signed averaging FIR. Each valid (w+2)-bit
//   running sum is divided by 4 with round-half-up to give the w-bit average.
//   The first TAPS sums after reset are discarded while the FIR delay line
//   fills. Averages kept after that go into a DEPTH-entry FIFO that the
//   consumer drains through a valid/ready handshake.
//
// Ports
//   clk       rising-edge clock
//   reset_n   asynchronous active-low reset; clears the FIFO and restarts warm-up
//   s_in      signed FIR sum (w+2 bits)
//   s_valid   s_in carries a new sum this cycle
//   m_data    signed rounded average at the FIFO head (w bits)
//   m_valid   m_data is valid (FIFO not empty)
//   m_ready   consumer takes m_data this cycle
//   level     FIFO occupancy, 0..DEPTH
//   primed    warm-up is done; sums are now kept
//   overflow  sticky: a kept sum was dropped because the FIFO was full
//   ovf_clr   synchronous clear of overflow; a same-cycle drop wins
module fir4_avg_outbuf #(
  parameter int w     = 16,
  parameter int DEPTH = 8,
  parameter int TAPS  = 4
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic signed [w+1:0]          s_in,
  input  logic                         s_valid,
  output logic        [w-1:0]          m_data,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic                         primed,
  output logic                         overflow,
  input  logic                         ovf_clr
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LW = $clog2(DEPTH+1);
  localparam int CW = $clog2(TAPS+1);

  // ---------------------------------------------------------------------------
  // Round-half-up divide by 4. The sum is sign-extended by one bit so that
  // adding 2 cannot wrap. Bits [w+1:2] are the low w bits of the arithmetic
  // shift; the FIR range guarantees they hold the whole result.
  // ---------------------------------------------------------------------------
  logic [w+2:0] rnd;
  logic [w-1:0] avg;
  logic [2:0]   unused_rnd;

  assign rnd        = {s_in[w+1], s_in} + (w+3)'(2);
  assign avg        = rnd[w+1:2];
  assign unused_rnd = {rnd[w+2], rnd[1:0]};

  // ---------------------------------------------------------------------------
  // Warm-up counter: counts valid sums up to TAPS, then holds. primed is
  // registered from the next count so it has no decode glitch.
  // ---------------------------------------------------------------------------
  logic [CW-1:0] wcnt, wcnt_nxt;

  always_comb begin
    wcnt_nxt = wcnt;
    if (s_valid && !primed) wcnt_nxt = wcnt + CW'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wcnt   <= '0;
      primed <= 1'b0;
    end else begin
      wcnt   <= wcnt_nxt;
      primed <= (wcnt_nxt == CW'(TAPS));
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO control. A pop frees a slot in the same cycle, so a full FIFO still
  // accepts a push when the consumer is taking the head.
  // ---------------------------------------------------------------------------
  logic [DEPTH-1:0][w-1:0] mem;
  logic [AW-1:0]           wr_ptr, rd_ptr;
  logic                    full, push, pop, drop;

  assign full    = (level == LW'(DEPTH));
  assign m_valid = (level != '0);
  assign pop     = m_valid && m_ready;
  assign push    = s_valid && primed && (!full || pop);
  assign drop    = s_valid && primed && full && !pop;
  assign m_data  = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= avg;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      level <= '0;
    end else if (push && !pop) begin
      level <= level + LW'(1);
    end else if (pop && !push) begin
      level <= level - LW'(1);
    end
  end

  // Sticky overflow; a new drop takes priority over the clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     overflow <= 1'b0;
    else if (drop)    overflow <= 1'b1;
    else if (ovf_clr) overflow <= 1'b0;
  end

endmodule
